// File: rtl/video_timing_pkg.sv
// Shared timing defaults, pattern encodings and colour-bar palette for the
// video test-pattern source.
package video_timing_pkg;

    // 640x480@60 default raster timing
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_COORD_W  = 12;

    // pattern_sel encodings
    localparam logic [1:0] PAT_SOLID = 2'd0;
    localparam logic [1:0] PAT_BARS  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_GRAD  = 2'd3;

    // Colour-bar palette, {r,g,b}
    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'hFF0000;
    localparam logic [23:0] COL_BLUE    = 24'h0000FF;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

    // Map a bar index (left to right) to its colour
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] col;
        case (idx)
            3'd0:    col = COL_WHITE;
            3'd1:    col = COL_YELLOW;
            3'd2:    col = COL_CYAN;
            3'd3:    col = COL_GREEN;
            3'd4:    col = COL_MAGENTA;
            3'd5:    col = COL_RED;
            3'd6:    col = COL_BLUE;
            3'd7:    col = COL_BLACK;
            default: col = COL_BLACK;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster position counters with combinational decode of the current position:
// active-video enable, sync levels and end-of-line / end-of-frame markers.
module video_timing_counter
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   COORD_W  = DEF_COORD_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic [COORD_W-1:0] hc_o,
    output logic [COORD_W-1:0] vc_o,
    output logic               de_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               line_end_o,
    output logic               frame_end_o
);

    localparam logic [COORD_W-1:0] ZERO_C     = COORD_W'(0);
    localparam logic [COORD_W-1:0] ONE_C      = COORD_W'(1);
    localparam logic [COORD_W-1:0] H_ACT_C    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] HS_BEG_C   = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END_C   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] H_LAST_C   = COORD_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [COORD_W-1:0] V_ACT_C    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] VS_BEG_C   = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END_C   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [COORD_W-1:0] V_LAST_C   = COORD_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [COORD_W-1:0] hc_q, hc_d;
    logic [COORD_W-1:0] vc_q, vc_d;

    // Next position: hc wraps each line, vc steps only at end of line
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (hc_q == H_LAST_C) begin
            hc_d = ZERO_C;
            if (vc_q == V_LAST_C) begin
                vc_d = ZERO_C;
            end else begin
                vc_d = vc_q + ONE_C;
            end
        end else begin
            hc_d = hc_q + ONE_C;
        end
    end

    // Position registers, restart at (0,0) on reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hc_q <= ZERO_C;
            vc_q <= ZERO_C;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    // Decode of the current position; the caller registers these
    always_comb begin
        de_o        = (hc_q < H_ACT_C) && (vc_q < V_ACT_C);
        hsync_o     = ((hc_q >= HS_BEG_C) && (hc_q < HS_END_C)) ? HS_POL : ~HS_POL;
        vsync_o     = ((vc_q >= VS_BEG_C) && (vc_q < VS_END_C)) ? VS_POL : ~VS_POL;
        line_end_o  = (hc_q == H_LAST_C);
        frame_end_o = (hc_q == H_LAST_C) && (vc_q == V_LAST_C);
    end

    assign hc_o = hc_q;
    assign vc_o = vc_q;

endmodule

// File: rtl/video_pattern_gen.sv
// Frame-coherent raster timing and test-pattern source. Every output is
// registered from the same counter position, one cycle behind the counters.
module video_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   COORD_W  = DEF_COORD_W
) (
    input  logic               pix_clk_i,
    input  logic               rst_i,
    input  logic [1:0]         pattern_sel_i,
    input  logic [23:0]        solid_rgb_i,
    output logic               de_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic [7:0]         r_o,
    output logic [7:0]         g_o,
    output logic [7:0]         b_o,
    output logic               frame_start_o,
    output logic [7:0]         frame_cnt_o
);

    localparam logic [COORD_W-1:0] ZERO_C     = COORD_W'(0);
    localparam logic [COORD_W-1:0] ONE_C      = COORD_W'(1);
    localparam logic [COORD_W-1:0] BAR_LAST_C = COORD_W'(H_ACTIVE / 8 - 1);

    logic [COORD_W-1:0] hc_s, vc_s;
    logic               de_s, hsync_s, vsync_s, line_end_s, frame_end_s;
    logic               frame_start_s;
    logic [23:0]        rgb_s;

    // Pattern state: latched pattern, frame counter, bar sub-counter
    logic [1:0]         pattern_q, pattern_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic [COORD_W-1:0] bar_px_q, bar_px_d;
    logic [2:0]         bar_idx_q, bar_idx_d;

    // Output register stage
    logic               de_q, hsync_q, vsync_q, frame_start_q;
    logic [COORD_W-1:0] x_q, y_q;
    logic [23:0]        rgb_q;
    logic [7:0]         frame_cnt_out_q;

    video_timing_counter #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HS_POL   (HS_POL),   .VS_POL (VS_POL), .COORD_W (COORD_W)
    ) u_timing (
        .clk_i       (pix_clk_i),
        .rst_i       (rst_i),
        .hc_o        (hc_s),
        .vc_o        (vc_s),
        .de_o        (de_s),
        .hsync_o     (hsync_s),
        .vsync_o     (vsync_s),
        .line_end_o  (line_end_s),
        .frame_end_o (frame_end_s)
    );

    assign frame_start_s = (hc_s == ZERO_C) && (vc_s == ZERO_C);

    // Frame-boundary latching and bar tracking that stays aligned with hc
    always_comb begin
        pattern_d   = pattern_q;
        frame_cnt_d = frame_cnt_q;
        bar_px_d    = bar_px_q;
        bar_idx_d   = bar_idx_q;
        if (frame_end_s) begin
            pattern_d   = pattern_sel_i;
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
            pattern_d   = pattern_q;
            frame_cnt_d = frame_cnt_q;
        end
        if (line_end_s) begin
            bar_px_d  = ZERO_C;
            bar_idx_d = 3'd0;
        end else if (bar_px_q == BAR_LAST_C) begin
            bar_px_d  = ZERO_C;
            bar_idx_d = bar_idx_q + 3'd1;
        end else begin
            bar_px_d  = bar_px_q + ONE_C;
        end
    end

    // Pattern state registers
    always_ff @(posedge pix_clk_i) begin
        if (rst_i) begin
            pattern_q   <= PAT_SOLID;
            frame_cnt_q <= 8'd0;
            bar_px_q    <= ZERO_C;
            bar_idx_q   <= 3'd0;
        end else begin
            pattern_q   <= pattern_d;
            frame_cnt_q <= frame_cnt_d;
            bar_px_q    <= bar_px_d;
            bar_idx_q   <= bar_idx_d;
        end
    end

    // Pixel colour for the current position; blank outside active video
    always_comb begin
        rgb_s = 24'h000000;
        if (de_s) begin
            case (pattern_q)
                PAT_SOLID: rgb_s = solid_rgb_i;
                PAT_BARS:  rgb_s = bar_colour(bar_idx_q);
                PAT_CHECK: rgb_s = (hc_s[5] ^ vc_s[5]) ? COL_BLACK : COL_WHITE;
                PAT_GRAD:  rgb_s = {hc_s[7:0] + frame_cnt_q, vc_s[7:0], 8'h80};
                default:   rgb_s = 24'h000000;
            endcase
        end else begin
            rgb_s = 24'h000000;
        end
    end

    // Output registers, all sampled from the same counter position
    always_ff @(posedge pix_clk_i) begin
        if (rst_i) begin
            de_q            <= 1'b0;
            hsync_q         <= ~HS_POL;
            vsync_q         <= ~VS_POL;
            x_q             <= ZERO_C;
            y_q             <= ZERO_C;
            rgb_q           <= 24'h000000;
            frame_start_q   <= 1'b0;
            frame_cnt_out_q <= 8'd0;
        end else begin
            de_q            <= de_s;
            hsync_q         <= hsync_s;
            vsync_q         <= vsync_s;
            x_q             <= hc_s;
            y_q             <= vc_s;
            rgb_q           <= rgb_s;
            frame_start_q   <= frame_start_s;
            frame_cnt_out_q <= frame_cnt_q;
        end
    end

    assign de_o          = de_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign r_o           = rgb_q[23:16];
    assign g_o           = rgb_q[15:8];
    assign b_o           = rgb_q[7:0];
    assign frame_start_o = frame_start_q;
    assign frame_cnt_o   = frame_cnt_out_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen using a reduced raster (80x55 total, 64x48
// active) so several frames fit in a short run. A pixel-position model checks
// every output on every cycle; directed checks pin known pixels.
module tb_video_pattern_gen;

    localparam int HA = 64, HFP = 4, HSW = 8, HBP = 4;
    localparam int VA = 48, VFP = 2, VSW = 2, VBP = 3;
    localparam int HT = HA + HFP + HSW + HBP;   // 80
    localparam int VT = VA + VFP + VSW + VBP;   // 55
    localparam int FRAME = HT * VT;             // 4400
    localparam int BW = HA / 8;                 // 8
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    pattern_sel = 2'd0;
    logic [23:0]   solid_rgb = 24'h123456;
    logic          de, hsync, vsync, frame_start;
    logic [CW-1:0] x, y;
    logic [7:0]    r, g, b, frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    video_pattern_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
        .HS_POL (1'b1), .VS_POL (1'b1), .COORD_W (CW)
    ) dut (
        .pix_clk_i     (clk),
        .rst_i         (rst),
        .pattern_sel_i (pattern_sel),
        .solid_rgb_i   (solid_rgb),
        .de_o          (de),
        .hsync_o       (hsync),
        .vsync_o       (vsync),
        .x_o           (x),
        .y_o           (y),
        .r_o           (r),
        .g_o           (g),
        .b_o           (b),
        .frame_start_o (frame_start),
        .frame_cnt_o   (frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic logic [23:0] exp_rgb(input int px, input int py, input int pat,
                                            input int fc, input logic [23:0] solid);
        logic [7:0] rr;
        logic [7:0] gg;
        if (!(px < HA && py < VA)) return 24'h000000;
        case (pat)
            0: return solid;
            1: return bar_tab[px / BW];
            2: return ((((px / 32) + (py / 32)) % 2) == 1) ? 24'h000000 : 24'hFFFFFF;
            3: begin
                rr = 8'((px + fc) % 256);
                gg = 8'(py % 256);
                return {rr, gg, 8'h80};
            end
            default: return 24'h000000;
        endcase
    endfunction

    int          m_x = 0, m_y = 0, m_fc = 0, m_pat = 0;
    bit          m_live = 1'b0;
    int          e_x, e_y, e_fc;
    logic        e_de, e_hs, e_vs, e_fs;
    logic [23:0] e_rgb;

    // Model steps with each edge, then compares shortly after it
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_live = 1'b1;
                e_x = 0; e_y = 0; e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0;
                e_rgb = 24'h0; e_fs = 1'b0; e_fc = 0;
                m_x = 0; m_y = 0; m_fc = 0; m_pat = 0;
            end else if (m_live) begin
                e_x   = m_x;
                e_y   = m_y;
                e_de  = (m_x < HA) && (m_y < VA);
                e_hs  = (m_x >= HA + HFP) && (m_x < HA + HFP + HSW);
                e_vs  = (m_y >= VA + VFP) && (m_y < VA + VFP + VSW);
                e_rgb = exp_rgb(m_x, m_y, m_pat, m_fc, solid_rgb);
                e_fs  = (m_x == 0) && (m_y == 0);
                e_fc  = m_fc;
                if (m_x == HT - 1 && m_y == VT - 1) begin
                    m_fc  = (m_fc + 1) % 256;
                    m_pat = int'(pattern_sel);
                end
                if (m_x == HT - 1) begin
                    m_x = 0;
                    m_y = (m_y == VT - 1) ? 0 : m_y + 1;
                end else begin
                    m_x = m_x + 1;
                end
            end
            #1;
            if (m_live) begin
                chk("m_x", 32'(x), 32'(e_x));
                chk("m_y", 32'(y), 32'(e_y));
                chk("m_de", 32'(de), 32'(e_de));
                chk("m_hsync", 32'(hsync), 32'(e_hs));
                chk("m_vsync", 32'(vsync), 32'(e_vs));
                chk("m_rgb", 32'({r, g, b}), 32'(e_rgb));
                chk("m_fstart", 32'(frame_start), 32'(e_fs));
                chk("m_fcnt", 32'(frame_cnt), 32'(e_fc));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int t_fs = 0;

    task automatic wait_pix(input int wx, input int wy);
        int n;
        n = 0;
        do begin
            @(posedge clk); #2; n++;
        end while (!(x == wx && y == wy) && n < 2 * FRAME + 10);
        chk("wait_xy_reached", 32'(x == wx && y == wy), 32'd1);
    endtask

    task automatic wait_fs(output int period);
        int n;
        n = 0;
        do begin
            @(posedge clk); #2; n++;
        end while (frame_start !== 1'b1 && n < 2 * FRAME + 10);
        chk("wait_fs_reached", 32'(frame_start), 32'd1);
        period = cyc - t_fs;
        t_fs = cyc;
    endtask

    initial begin
        int de_cnt, hs_first, hs_last, per;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("rst_de", 32'(de), 32'd0);
        chk("rst_hsync", 32'(hsync), 32'd0);
        chk("rst_vsync", 32'(vsync), 32'd0);
        chk("rst_rgb", 32'({r, g, b}), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk); #2;
        t_fs = cyc;
        chk("first_x", 32'(x), 32'd0);
        chk("first_y", 32'(y), 32'd0);
        chk("first_de", 32'(de), 32'd1);
        chk("first_fs", 32'(frame_start), 32'd1);
        chk("first_rgb", 32'({r, g, b}), 32'h123456);

        // One full line: de count, hsync window, line period
        de_cnt = 0; hs_first = -1; hs_last = -1;
        for (int i = 0; i < HT; i++) begin
            if (i > 0) begin
                @(posedge clk); #2;
            end
            if (de) de_cnt++;
            if (hsync) begin
                if (hs_first < 0) hs_first = int'(x);
                hs_last = int'(x);
            end
        end
        chk("line_de_cnt", 32'(de_cnt), 32'd64);
        chk("line_hs_first", 32'(hs_first), 32'd68);
        chk("line_hs_last", 32'(hs_last), 32'd75);
        @(posedge clk); #2;
        chk("line_wrap_x", 32'(x), 32'd0);
        chk("line_wrap_y", 32'(y), 32'd1);

        // Bars requested mid-frame; applied from next frame
        pattern_sel = 2'd1;
        wait_pix(10, 5);
        chk("no_tear_solid", 32'({r, g, b}), 32'h123456);
        wait_fs(per);
        chk("frame_period1", 32'(per), 32'(FRAME));
        chk("fcnt_1", 32'(frame_cnt), 32'd1);
        chk("bar_x0", 32'({r, g, b}), 32'hFFFFFF);
        wait_pix(7, 0);  chk("bar_x7", 32'({r, g, b}), 32'hFFFFFF);
        wait_pix(8, 0);  chk("bar_x8", 32'({r, g, b}), 32'hFFFF00);
        wait_pix(47, 0); chk("bar_x47", 32'({r, g, b}), 32'hFF0000);
        wait_pix(48, 0); chk("bar_x48", 32'({r, g, b}), 32'h0000FF);
        wait_pix(63, 0); chk("bar_x63", 32'({r, g, b}), 32'h000000);
        wait_pix(64, 0); chk("blank_x64", 32'({r, g, b}), 32'h000000);

        // Switch to checkerboard mid-frame
        wait_pix(0, 10);
        pattern_sel = 2'd2;
        wait_pix(8, 11); chk("bars_kept", 32'({r, g, b}), 32'hFFFF00);
        wait_pix(0, 49); chk("vs_y49", 32'(vsync), 32'd0);
        wait_pix(0, 50); chk("vs_y50", 32'(vsync), 32'd1);
        wait_pix(79, 51); chk("vs_y51", 32'(vsync), 32'd1);
        wait_pix(0, 52); chk("vs_y52", 32'(vsync), 32'd0);
        wait_fs(per);
        chk("frame_period2", 32'(per), 32'(FRAME));
        chk("fcnt_2", 32'(frame_cnt), 32'd2);
        wait_pix(31, 0);  chk("chk_31_0", 32'({r, g, b}), 32'hFFFFFF);
        wait_pix(32, 0);  chk("chk_32_0", 32'({r, g, b}), 32'h000000);
        wait_pix(0, 32);  chk("chk_0_32", 32'({r, g, b}), 32'h000000);
        wait_pix(32, 32); chk("chk_32_32", 32'({r, g, b}), 32'hFFFFFF);

        // Gradient: r = x + frame_cnt
        pattern_sel = 2'd3;
        wait_fs(per);
        chk("fcnt_3", 32'(frame_cnt), 32'd3);
        wait_pix(5, 2); chk("grad_5_2", 32'({r, g, b}), 32'h080280);

        // One-cycle reset mid-frame
        wait_pix(30, 20);
        rst = 1'b1;
        @(posedge clk); #2;
        chk("mrst_de", 32'(de), 32'd0);
        chk("mrst_rgb", 32'({r, g, b}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #2;
        t_fs = cyc;
        chk("mrst_x", 32'(x), 32'd0);
        chk("mrst_y", 32'(y), 32'd0);
        chk("mrst_fs", 32'(frame_start), 32'd1);
        chk("mrst_fcnt", 32'(frame_cnt), 32'd0);
        chk("mrst_solid", 32'({r, g, b}), 32'h123456);
        wait_fs(per);
        chk("frame_period3", 32'(per), 32'(FRAME));
        chk("fcnt_after_rst", 32'(frame_cnt), 32'd1);
        wait_pix(5, 2); chk("grad2_5_2", 32'({r, g, b}), 32'h060280);
        repeat (20) @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
